// File: rtl/color_channel_ctrl.sv
// color_channel_ctrl
//   Debounces three push-buttons and maintains a packed multi-channel colour
//   word. PB[1] cycles the selected channel. PB[2] increments the selected
//   channel and PB[0] decrements it, each with optional auto-repeat while held.
//   A LOAD strobe overwrites the whole word.
//
// Ports
//   CLK         in   clock
//   RESET       in   synchronous, active-high reset
//   PB[2:0]     in   raw async buttons: [2]=increment, [1]=select, [0]=decrement
//   WRAP_EN     in   0 = saturate at field limits, 1 = wrap modulo 2^w
//   LOAD_VALID  in   single-cycle strobe that overwrites COLOR
//   LOAD_DATA   in   value written on LOAD_VALID
//   COLOR       out  registered packed colour word (channel 0 in the LSBs)
//   SEL_IDX     out  registered index of the selected channel
//   CHANGED     out  one-cycle pulse, aligned with each new COLOR value
module color_channel_ctrl #(
    parameter int unsigned         N_CH            = 3,
    parameter logic [4*N_CH-1:0]   CH_WIDTHS       = 12'h565,
    parameter int unsigned         TOTAL_W         = 16,
    parameter logic [TOTAL_W-1:0]  RESET_COLOR     = '0,
    parameter int unsigned         DEBOUNCE_CYCLES = 500000,
    parameter int unsigned         REPEAT_DELAY    = 5000000,
    parameter int unsigned         REPEAT_PERIOD   = 1000000
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [2:0]                PB,
    input  logic                      WRAP_EN,
    input  logic                      LOAD_VALID,
    input  logic [TOTAL_W-1:0]        LOAD_DATA,
    output logic [TOTAL_W-1:0]        COLOR,
    output logic [$clog2(N_CH)-1:0]   SEL_IDX,
    output logic                      CHANGED
);

    localparam int unsigned SEL_W    = $clog2(N_CH);
    localparam int unsigned DB_W     = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                       ((REPEAT_DELAY > 0) ? REPEAT_DELAY : 1) :
                                       ((REPEAT_PERIOD > 0) ? REPEAT_PERIOD : 1);
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_MAX = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W:0]   RD_L   = (HOLD_W + 1)'(REPEAT_DELAY);
    localparam logic [HOLD_W:0]   RP_L   = (HOLD_W + 1)'(REPEAT_PERIOD);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    // Width of channel c
    function automatic int unsigned ch_w(input int unsigned c);
        return 32'(CH_WIDTHS[4*c +: 4]);
    endfunction

    // Bit offset of channel c inside COLOR
    function automatic int unsigned ch_off(input int unsigned c);
        int unsigned acc;
        acc = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (i < c) acc = acc + ch_w(i);
        end
        return acc;
    endfunction

    function automatic logic [TOTAL_W-1:0] field_mask(input int unsigned w);
        logic [TOTAL_W-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < TOTAL_W; b++) begin
            if (b < w) m[b] = 1'b1;
        end
        return m;
    endfunction

    logic [2:0]          sync1, sync2;
    logic [2:0]          db;
    logic [DB_W-1:0]     db_cnt [3];

    state_t              state;
    logic [2:0]          held;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W:0]     hold_next;

    logic                db_one_hot;
    logic                fire;
    logic [2:0]          act;

    int unsigned         sel_off;
    logic [TOTAL_W-1:0]  sel_mask;
    logic [TOTAL_W-1:0]  field;
    logic [TOTAL_W-1:0]  field_new;
    logic [TOTAL_W-1:0]  color_act;

    // Synchroniser and per-bit debounce: DB follows the synchronised level
    // only after it has differed for DEBOUNCE_CYCLES+1 consecutive samples.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            for (int unsigned b = 0; b < 3; b++) db_cnt[b] <= '0;
        end else begin
            sync1 <= PB;
            sync2 <= sync1;
            for (int unsigned b = 0; b < 3; b++) begin
                if (sync2[b] == db[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_MAX) begin
                    db[b]     <= sync2[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + DB_W'(1);
                end
            end
        end
    end

    assign db_one_hot = (db == 3'b001) || (db == 3'b010) || (db == 3'b100);
    assign hold_next  = {1'b0, hold_cnt} + (HOLD_W + 1)'(1);

    // Action timing
    always_comb begin
        fire = 1'b0;
        act  = held;
        case (state)
            IDLE: begin
                fire = db_one_hot;
                act  = db;
            end
            DELAY:  fire = (db == held) && !held[1] && (REPEAT_PERIOD != 0) && (hold_next >= RD_L);
            REPEAT: fire = (db == held) && (hold_next >= RP_L);
            default: fire = 1'b0;
        endcase
    end

    // Field arithmetic on the selected channel, done in full-word width with
    // a runtime mask/offset so channel widths can differ.
    always_comb begin
        sel_off  = 0;
        sel_mask = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (SEL_IDX == SEL_W'(i)) begin
                sel_off  = ch_off(i);
                sel_mask = field_mask(ch_w(i));
            end
        end
        field = (COLOR >> sel_off) & sel_mask;
        if (act[2]) begin
            field_new = (!WRAP_EN && field == sel_mask) ? field : ((field + TOTAL_W'(1)) & sel_mask);
        end else if (act[0]) begin
            field_new = (!WRAP_EN && field == '0) ? field : ((field - TOTAL_W'(1)) & sel_mask);
        end else begin
            field_new = field;
        end
        color_act = (COLOR & ~(sel_mask << sel_off)) | (field_new << sel_off);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            held     <= '0;
            hold_cnt <= '0;
            COLOR    <= RESET_COLOR;
            SEL_IDX  <= '0;
            CHANGED  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (db_one_hot) begin
                        state    <= DELAY;
                        held     <= db;
                        hold_cnt <= '0;
                    end
                end
                DELAY, REPEAT: begin
                    if (db != held) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else if (fire) begin
                        state    <= REPEAT;
                        hold_cnt <= '0;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // A load discards any button action firing in the same cycle,
            // including a select; the FSM still advances normally.
            if (LOAD_VALID) begin
                COLOR   <= LOAD_DATA;
                CHANGED <= (LOAD_DATA != COLOR);
            end else if (fire && (act[2] || act[0])) begin
                COLOR   <= color_act;
                CHANGED <= (color_act != COLOR);
            end else begin
                CHANGED <= 1'b0;
            end

            if (!LOAD_VALID && fire && act[1]) begin
                SEL_IDX <= (SEL_IDX == SEL_W'(N_CH - 1)) ? '0 : SEL_IDX + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_color_channel_ctrl.sv
// tb_color_channel_ctrl
//   Self-checking bench for color_channel_ctrl with short debounce/repeat
//   timings. A behavioural model tracks button levels, press age and the
//   colour word; a compare process checks COLOR/SEL_IDX/CHANGED every cycle.
//   Directed scenarios pin the model with hand-computed values, then a
//   randomized phase exercises glitches, button switches, loads and resets.
module tb_color_channel_ctrl;

    localparam int unsigned N_CH    = 3;
    localparam int unsigned TOTAL_W = 16;
    localparam int          DB      = 4;
    localparam int          RD      = 20;
    localparam int          RP      = 8;
    localparam logic [11:0] CHW     = 12'h565;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  pb = 3'b000;
    logic        wrap_en = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0000;
    logic [15:0] color;
    logic [1:0]  sel_idx;
    logic        changed;

    color_channel_ctrl #(
        .N_CH(N_CH),
        .CH_WIDTHS(CHW),
        .TOTAL_W(TOTAL_W),
        .RESET_COLOR(16'h0000),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .PB(pb),
        .WRAP_EN(wrap_en),
        .LOAD_VALID(load_valid),
        .LOAD_DATA(load_data),
        .COLOR(color),
        .SEL_IDX(sel_idx),
        .CHANGED(changed)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int changed_cnt = 0;

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_total++;
        if (a !== e) $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0]  m_pipe [2];
    logic [2:0]  m_db;
    int          m_run [3];
    bit          m_pressed;
    logic [2:0]  m_btn;
    int          m_age;
    logic [15:0] m_color;
    int          m_sel;
    bit          m_changed;
    bit          m_valid = 1'b0;

    function automatic int chw(input int c);
        logic [11:0] t;
        t = CHW >> (4 * c);
        return int'(t[3:0]);
    endfunction

    task automatic model_step();
        bit         fire;
        logic [2:0] act;
        int         w, off, lim, f, nf, c, nc;
        if (rst) begin
            m_pipe[0] = 3'b000; m_pipe[1] = 3'b000;
            m_db = 3'b000;
            for (int b = 0; b < 3; b++) m_run[b] = 0;
            m_pressed = 1'b0; m_btn = 3'b000; m_age = 0;
            m_color = 16'h0000; m_sel = 0; m_changed = 1'b0;
            return;
        end
        // press tracking, from the debounced level before this edge
        fire = 1'b0;
        act  = m_btn;
        if (!m_pressed) begin
            if ($countones(m_db) == 1) begin
                fire = 1'b1; act = m_db;
                m_pressed = 1'b1; m_btn = m_db; m_age = 0;
            end
        end else if (m_db != m_btn) begin
            m_pressed = 1'b0;
        end else begin
            m_age++;
            if (m_btn != 3'b010 && RP != 0 && m_age >= RD && (m_age - RD) % RP == 0) fire = 1'b1;
        end
        // colour / selection
        m_changed = 1'b0;
        if (load_valid) begin
            m_changed = (load_data != m_color);
            m_color = load_data;
        end else if (fire) begin
            if (act == 3'b010) begin
                m_sel = (m_sel == N_CH - 1) ? 0 : m_sel + 1;
            end else begin
                w = chw(m_sel);
                off = 0;
                for (int i = 0; i < m_sel; i++) off += chw(i);
                lim = (1 << w) - 1;
                c = int'(m_color);
                f = (c >> off) & lim;
                nf = f;
                if (act == 3'b100) begin
                    if (wrap_en || f != lim) nf = (f + 1) % (lim + 1);
                end else begin
                    if (wrap_en || f != 0) nf = (f + lim) % (lim + 1);
                end
                nc = (c & ~(lim << off)) | (nf << off);
                m_changed = (16'(nc) != m_color);
                m_color = 16'(nc);
            end
        end
        // debounce: a run of DB+1 differing samples flips the level
        for (int b = 0; b < 3; b++) begin
            if (m_pipe[1][b] != m_db[b]) begin
                if (m_run[b] == DB) begin
                    m_db[b] = m_pipe[1][b];
                    m_run[b] = 0;
                end else begin
                    m_run[b]++;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = pb;
    endtask

    always @(posedge clk) begin
        model_step();
        m_valid = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("color", 32'(color), 32'(m_color));
            check("sel_idx", 32'(sel_idx), 32'(m_sel));
            check("changed", 32'(changed), 32'(m_changed));
            if (changed === 1'b1) changed_cnt++;
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input logic [2:0] b);
        pb = b; cyc(12);
        pb = 3'b000; cyc(12);
    endtask

    // edges from the first edge after the call until COLOR or SEL_IDX moves
    task automatic wait_change(output int lat);
        logic [15:0] c0;
        logic [1:0]  s0;
        c0 = color; s0 = sel_idx; lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (color !== c0 || sel_idx !== s0) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(2);
        rst = 1'b0; cyc(1);
    endtask

    initial begin
        int lat, snap;
        int exp_sel [4];
        int times [$];
        logic [15:0] prev;
        int r;
        exp_sel = '{1, 2, 0, 1};

        cyc(2);
        check("reset_color", 32'(color), 32'h0);
        check("reset_sel", 32'(sel_idx), 32'h0);
        check("reset_changed", 32'(changed), 32'h0);
        rst = 1'b0;

        // 1: all three buttons together are not a press
        snap = changed_cnt;
        pb = 3'b111; cyc(100);
        check("multi_color", 32'(color), 32'h0);
        check("multi_sel", 32'(sel_idx), 32'h0);
        pb = 3'b000; cyc(15);
        check("multi_changed_cnt", 32'(changed_cnt - snap), 32'h0);

        // 2: select taps
        for (int k = 0; k < 4; k++) begin
            pb = 3'b010;
            wait_change(lat);
            check("sel_latency", 32'(lat), 32'd7);
            check("sel_seq", 32'(sel_idx), 32'(exp_sel[k]));
            cyc(5);
            pb = 3'b000; cyc(12);
        end
        check("sel_color_kept", 32'(color), 32'h0);

        // 3: increment held on channel 0, saturating
        do_reset();
        wrap_en = 1'b0;
        snap = changed_cnt;
        prev = color;
        pb = 3'b100;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (color !== prev) times.push_back(i - 1);
            prev = color;
        end
        pb = 3'b000; cyc(15);
        check("sat_color", 32'(color), 32'h001F);
        check("sat_steps", 32'(times.size()), 32'd31);
        check("sat_first", 32'(times[0]), 32'd7);
        check("sat_delay", 32'(times[1] - times[0]), 32'd20);
        check("sat_period", 32'(times[2] - times[1]), 32'd8);
        check("sat_changed_cnt", 32'(changed_cnt - snap), 32'd31);

        // 4: wrap on the 6-bit channel
        do_reset();
        tap(3'b010);
        wrap_en = 1'b1;
        tap(3'b001);
        check("wrap_dec", 32'(color), 32'h07E0);
        tap(3'b100);
        check("wrap_inc", 32'(color), 32'h0000);

        // 5: load collides with an increment action
        snap = changed_cnt;
        pb = 3'b100; cyc(7);
        load_valid = 1'b1; load_data = 16'hF81F; cyc(1);
        load_valid = 1'b0;
        check("load_color", 32'(color), 32'hF81F);
        check("load_changed", 32'(changed), 32'h1);
        cyc(4);
        pb = 3'b000; cyc(12);
        check("load_kept", 32'(color), 32'hF81F);
        check("load_changed_cnt", 32'(changed_cnt - snap), 32'd1);

        // 6: reset during auto-repeat with increment still held
        pb = 3'b100; cyc(45);
        rst = 1'b1; cyc(1);
        check("rst_hold_color", 32'(color), 32'h0);
        check("rst_hold_sel", 32'(sel_idx), 32'h0);
        cyc(1);
        rst = 1'b0;
        wait_change(lat);
        check("rst_hold_latency", 32'(lat), 32'(DB + 3));
        check("rst_hold_first", 32'(color), 32'h0001);
        pb = 3'b000; cyc(15);

        // randomized phase, checked by the model
        for (int it = 0; it < 160; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      pb = 3'b001 << (r % 3);
            else if (r == 7) pb = 3'($urandom_range(0, 7));
            else             pb = 3'b000;
            if ($urandom_range(0, 3) == 0) wrap_en = ~wrap_en;
            repeat ($urandom_range(1, 60)) begin
                load_valid = ($urandom_range(0, 29) == 0);
                load_data  = 16'($urandom);
                rst        = ($urandom_range(0, 299) == 0);
                cyc(1);
            end
            load_valid = 1'b0;
            rst = 1'b0;
        end
        pb = 3'b000; cyc(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
